// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: FSM states, ROM entry layout
// and the rules for turning a raw entry into a playable note and beat count.
package song_pkg;

  localparam int unsigned ENTRY_W  = 8;
  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned DUR_W    = 4;
  localparam int unsigned NOTE_LSB = 4;
  localparam int unsigned DUR_LSB  = 0;
  localparam int unsigned SEL_W    = 2;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 4'hF;
  localparam logic [NOTE_W-1:0] NOTE_MAX  = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    DONE
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  // Codes above NOTE_MAX (other than END) play as silence.
  function automatic logic [NOTE_W-1:0] play_note(input entry_t e);
    return (e.note <= NOTE_MAX) ? e.note : NOTE_REST;
  endfunction

  // A zero duration still occupies one beat.
  function automatic logic [DUR_W-1:0] beats_of(input entry_t e);
    return (e.dur == '0) ? DUR_W'(1) : e.dur;
  endfunction

endpackage

// File: rtl/song_player_if.sv
// Control/status bundle between a song_player and whoever drives it.
interface song_player_if import song_pkg::*; ();

  logic              start;
  logic              pause;
  logic              stop;
  logic [SEL_W-1:0]  song_sel;
  logic [NOTE_W-1:0] song_note;
  logic              playing;
  logic              done;

  modport master (
    output start, pause, stop, song_sel,
    input  song_note, playing, done
  );

  modport slave (
    input  start, pause, stop, song_sel,
    output song_note, playing, done
  );

endinterface

// File: rtl/song_rom.sv
// Synchronous-read song ROM; contents come from the ROM_DATA parameter
// (entry at address a lives in bits [8a+7:8a]).
module song_rom import song_pkg::*; #(
  parameter int unsigned AW = 8,
  parameter logic [ENTRY_W*(2**AW)-1:0] ROM_DATA = {(2**AW){8'hF0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  output entry_t        data
);

  localparam int unsigned DEPTH = 2**AW;

  logic [ENTRY_W-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign mem[i] = ROM_DATA[i*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= '{note: mem[addr][NOTE_LSB +: NOTE_W], dur: mem[addr][DUR_LSB +: DUR_W]};
    end
  end

endmodule

// File: rtl/song_player.sv
// Walks one song in ROM entry by entry, holding each note for its beat count
// followed by an optional silent gap; start/pause/stop control the walk.
module song_player import song_pkg::*; #(
  parameter int unsigned CLK_PER_BEAT = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000,
  parameter int unsigned ADDR_W       = 6,
  parameter logic [ENTRY_W*(2**(ADDR_W+SEL_W))-1:0] ROM_DATA = {(2**(ADDR_W+SEL_W)){8'hF0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  song_player_if.slave bus
);

  localparam int unsigned ROM_AW   = ADDR_W + SEL_W;
  localparam int unsigned DIV_W    = $clog2(CLK_PER_BEAT);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned DIV_LAST = CLK_PER_BEAT - 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DUR_W-1:0]    beat_q, beat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                playing_q, done_q;
  logic                adv;
  logic [ROM_AW-1:0]   rom_addr;
  entry_t              rom_q;

  // Address is the next-cycle index so the entry is ready during FETCH.
  song_rom #(
    .AW       (ROM_AW),
    .ROM_DATA (ROM_DATA)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (rom_addr),
    .data  (rom_q)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    div_d   = div_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    note_d  = note_q;
    adv     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d   = bus.song_sel;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (rom_q.note == NOTE_END) begin
          note_d  = NOTE_REST;
          state_d = DONE;
        end else begin
          note_d  = play_note(rom_q);
          beat_d  = beats_of(rom_q);
          div_d   = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (!bus.pause) begin
          if (div_q == DIV_W'(DIV_LAST)) begin
            div_d  = '0;
            beat_d = beat_q - DUR_W'(1);
            if (beat_q == DUR_W'(1)) begin
              if (GAP_CYCLES > 0) begin
                note_d  = NOTE_REST;
                gap_d   = '0;
                state_d = GAP;
              end else begin
                adv = 1'b1;
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      GAP: begin
        if (!bus.pause) begin
          if (gap_q == GAP_W'(GAP_LAST)) begin
            gap_d = '0;
            adv   = 1'b1;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      DONE: begin
        note_d  = NOTE_REST;
        state_d = IDLE;
      end
      default: begin
        note_d  = NOTE_REST;
        state_d = IDLE;
      end
    endcase

    // The last slot ends the song rather than wrapping the index.
    if (adv) begin
      note_d = NOTE_REST;
      if (idx_q == '1) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = FETCH;
      end
    end

    if (bus.stop) begin
      state_d = IDLE;
      note_d  = NOTE_REST;
      div_d   = '0;
      beat_d  = '0;
      gap_d   = '0;
    end

    rom_addr = {sel_d, idx_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sel_q     <= '0;
      div_q     <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      note_q    <= NOTE_REST;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      div_q     <= div_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      note_q    <= note_d;
      playing_q <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.song_note = note_q;
  assign bus.playing   = playing_q;
  assign bus.done      = done_q;

endmodule
